// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front-end that drives the ALU result-mux bank and returns result plus flags
//   Optional feature macro: ALU_SEQ_PARITY_EN (builds the PF flag; otherwise res_pf is tied low).
//   Ports: clk, rst (sync, active-high);
//          cmd_valid/cmd_ready with cmd_op, cmd_a, cmd_b, cmd_cnt (accepted only in IDLE);
//          alu_op/alu_a/alu_b out to the datapath, alu_r/alu_cf back from it;
//          res_valid/res_ready with res_data, res_zf, res_sf, res_cf, res_pf; busy.
module alu_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_cf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zf,
    output logic             res_sf,
    output logic             res_cf,
    output logic             res_pf,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d, b_q, b_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic cf_q, cf_d;
    logic done;
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        acc_d = acc_q;
        b_d = b_q;
        rem_d = rem_q;
        cf_d = cf_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                op_d = cmd_op;
                acc_d = cmd_a;
                b_d = cmd_b;
                rem_d = cmd_cnt;
                cf_d = 1'b0;
                // A zero-count shift/rotate is a no-op: skip straight to the result.
                state_d = (cmd_op[3:2] == 2'b11 && cmd_cnt == '0) ? DONE : EXEC;
            end
            EXEC: begin
                acc_d = alu_r;
                cf_d = alu_cf;
                if (op_q[3:2] == 2'b11 && rem_q > CNT_W'(1))
                    rem_d = rem_q - CNT_W'(1);
                else
                    state_d = DONE;
            end
            DONE: state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q <= '0;
            acc_q <= '0;
            b_q <= '0;
            rem_q <= '0;
            cf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            acc_q <= acc_d;
            b_q <= b_d;
            rem_q <= rem_d;
            cf_q <= cf_d;
        end
    end
    assign done = state_q == DONE;
    assign cmd_ready = state_q == IDLE;
    assign busy = state_q != IDLE;
    assign alu_op = op_q;
    assign alu_a = acc_q;
    assign alu_b = b_q;
    assign res_valid = done;
    // Result and flags are gated so they read zero outside DONE.
    assign res_data = done ? acc_q : '0;
    assign res_zf = done && acc_q == '0;
    assign res_sf = done && acc_q[WIDTH-1];
    assign res_cf = done && cf_q;
`ifdef ALU_SEQ_PARITY_EN
    assign res_pf = done && ~^acc_q[7:0];
`else
    assign res_pf = 1'b0;
`endif
endmodule
